// File: rtl/stream_pkg.sv
// Shared stream arbitration types and the round-robin selection helper.
package stream_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  localparam int unsigned MaxSrc  = 32;
  localparam int unsigned MaxIdxW = 5;

  // First set bit of req scanning upward from last+1, wrapping mod n; returns last if req is empty.
  function automatic logic [MaxIdxW-1:0] rr_next(input logic [MaxSrc-1:0] req,
                                                 input logic [MaxIdxW-1:0] last,
                                                 input int unsigned n);
    logic [MaxIdxW-1:0] pick;
    logic               found;
    int                 idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= int'(MaxSrc); i++) begin
      idx = (int'(last) + i) % int'(n);
      if (i <= int'(n) && !found && req[idx[MaxIdxW-1:0]]) begin
        pick  = idx[MaxIdxW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/stream_packet_arbiter_if.sv
// Handshake bundle between N narrow requesters, the arbiter and the downstream upsizer port.
interface stream_packet_arbiter_if #(
  parameter int unsigned T_DATA_WIDTH = 1,
  parameter int unsigned N_SRC        = 4
);
  localparam int unsigned ID_WIDTH = $clog2(N_SRC);

  logic [N_SRC-1:0]                   src_en_i;
  logic [N_SRC-1:0][T_DATA_WIDTH-1:0] s_data_i;
  logic [N_SRC-1:0]                   s_last_i;
  logic [N_SRC-1:0]                   s_valid_i;
  logic [N_SRC-1:0]                   s_ready_o;
  logic [T_DATA_WIDTH-1:0]            m_data_o;
  logic                               m_last_o;
  logic                               m_valid_o;
  logic                               m_ready_i;
  logic [ID_WIDTH-1:0]                m_id_o;
  logic                               busy_o;

  modport slave (
    input  src_en_i, s_data_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_last_o, m_valid_o, m_id_o, busy_o
  );

  modport master (
    output src_en_i, s_data_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_last_o, m_valid_o, m_id_o, busy_o
  );

endinterface

// File: rtl/stream_packet_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest-index request above last_i wins, with wrap.
module rr_picker
  import stream_pkg::*;
#(
  parameter  int unsigned N   = 4,
  localparam int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] last_i,
  output logic [N-1:0]   gnt_onehot_o,
  output logic [IdW-1:0] gnt_idx_o,
  output logic           any_o
);

  logic [MaxIdxW-1:0] pick;

  assign pick         = rr_next(MaxSrc'(req_i), MaxIdxW'(last_i), N);
  assign gnt_idx_o    = pick[IdW-1:0];
  assign any_o        = |req_i;
  assign gnt_onehot_o = any_o ? (N'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin arbiter feeding one registered stream stage into a shared upsizer.
module stream_packet_arbiter
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 1,
  parameter int unsigned N_SRC        = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  stream_packet_arbiter_if.slave bus
);

  localparam int unsigned ID_WIDTH = $clog2(N_SRC);

  arb_state_t              state_q, state_d;
  logic [ID_WIDTH-1:0]     grant_q, grant_d;
  logic [N_SRC-1:0]        grant_oh_q, grant_oh_d;
  logic [ID_WIDTH-1:0]     last_grant_q, last_grant_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [ID_WIDTH-1:0]     m_id_q, m_id_d;

  logic [N_SRC-1:0]        req;
  logic [N_SRC-1:0]        pick_oh;
  logic [ID_WIDTH-1:0]     pick_idx;
  logic                    pick_any;
  logic [N_SRC-1:0]        ready;
  logic                    out_free;
  logic                    accept;

  assign req = bus.s_valid_i & bus.src_en_i;

  rr_picker #(
    .N (N_SRC)
  ) u_picker (
    .req_i        (req),
    .last_i       (last_grant_q),
    .gnt_onehot_o (pick_oh),
    .gnt_idx_o    (pick_idx),
    .any_o        (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    m_data_d     = m_data_q;
    m_id_d       = m_id_q;
    ready        = '0;
    accept       = 1'b0;
    out_free     = !m_valid_q || bus.m_ready_i;

    unique case (state_q)
      ARB_IDLE: begin
        // Arbitration cycle: no beat is taken while the new grant is registered.
        if (pick_any) begin
          grant_d    = pick_idx;
          grant_oh_d = pick_oh;
          state_d    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        ready  = out_free ? grant_oh_q : '0;
        accept = |(bus.s_valid_i & ready);
        if (accept && bus.s_last_i[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = bus.s_data_i[grant_q];
      m_last_d  = bus.s_last_i[grant_q];
      m_id_d    = grant_q;
    end else if (bus.m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= ID_WIDTH'(N_SRC - 1);
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      m_id_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_data_q     <= m_data_d;
      m_id_q       <= m_id_d;
    end
  end

  assign bus.s_ready_o = ready;
  assign bus.m_valid_o = m_valid_q;
  assign bus.m_last_o  = m_last_q;
  assign bus.m_data_o  = m_data_q;
  assign bus.m_id_o    = m_id_q;
  assign bus.busy_o    = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed bench for stream_packet_arbiter with per-source scoreboard queues.
module tb_stream_packet_arbiter;

  localparam int unsigned W = 1;
  localparam int unsigned N = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  stream_packet_arbiter_if #(.T_DATA_WIDTH(W), .N_SRC(N)) bus ();

  stream_packet_arbiter #(
    .T_DATA_WIDTH (W),
    .N_SRC        (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  beat_t src_q [N][$];
  beat_t exp_q [N][$];
  int    obs_id[$];
  int    obs_cyc[$];
  logic  obs_last[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input int s, input int len, input logic [31:0] pat);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = W'(pat >> k);
      b.last = (k == len - 1);
      src_q[s].push_back(b);
      exp_q[s].push_back(b);
    end
  endtask

  task automatic clear_obs();
    obs_id.delete();
    obs_cyc.delete();
    obs_last.delete();
  endtask

  task automatic wait_obs(input int n, input int budget, input string tag);
    int k = 0;
    while (obs_id.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, 32'(obs_id.size() >= n), 1);
  endtask

  task automatic check_ids(input string tag, input int first, input int exp_ids[$]);
    for (int i = 0; i < exp_ids.size(); i++) begin
      if (first + i < obs_id.size()) check(tag, obs_id[first + i], exp_ids[i]);
    end
  endtask

  // Source drivers plus output monitor: handshakes sampled at negedge, inputs updated after posedge.
  initial begin : agent
    logic [N-1:0] fire;
    logic         stall_v;
    logic [W-1:0] st_data;
    logic         st_last;
    logic [1:0]   st_id;
    beat_t        e;
    int           id;
    bus.s_valid_i = '0;
    bus.s_data_i  = '0;
    bus.s_last_i  = '0;
    stall_v       = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      fire = bus.s_valid_i & bus.s_ready_o;
      if (rst_n) begin
        check("ready_onehot0", 32'($onehot0(bus.s_ready_o)), 1);
        if (stall_v) begin
          check("stall_valid", 32'(bus.m_valid_o), 1);
          check("stall_data", 32'(bus.m_data_o), 32'(st_data));
          check("stall_last", 32'(bus.m_last_o), 32'(st_last));
          check("stall_id", 32'(bus.m_id_o), 32'(st_id));
        end
        if (bus.m_valid_o && bus.m_ready_i) begin
          id = int'(bus.m_id_o);
          check("sb_nonempty", 32'(exp_q[id].size() > 0), 1);
          if (exp_q[id].size() > 0) begin
            e = exp_q[id].pop_front();
            check("sb_data", 32'(bus.m_data_o), 32'(e.data));
            check("sb_last", 32'(bus.m_last_o), 32'(e.last));
          end
          obs_id.push_back(id);
          obs_cyc.push_back(cyc);
          obs_last.push_back(bus.m_last_o);
        end
        stall_v = bus.m_valid_o && !bus.m_ready_i;
        st_data = bus.m_data_o;
        st_last = bus.m_last_o;
        st_id   = bus.m_id_o;
      end else begin
        stall_v = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          bus.s_valid_i[i] = 1'b1;
          bus.s_data_i[i]  = src_q[i][0].data;
          bus.s_last_i[i]  = src_q[i][0].last;
        end else begin
          bus.s_valid_i[i] = 1'b0;
        end
      end
    end
  end

  initial begin : main
    int rel_cyc;
    bus.m_ready_i = 1'b1;
    bus.src_en_i  = '1;

    // Reset with every source valid; then one single-beat packet per source.
    for (int s = 0; s < N; s++) push_pkt(s, 1, s & 1);
    repeat (3) @(posedge clk);
    #2;
    check("rst_m_valid", 32'(bus.m_valid_o), 0);
    check("rst_m_last", 32'(bus.m_last_o), 0);
    check("rst_m_data", 32'(bus.m_data_o), 0);
    check("rst_m_id", 32'(bus.m_id_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_s_ready", 32'(bus.s_ready_o), 0);
    @(posedge clk);
    #2;
    clear_obs();
    rel_cyc = cyc;
    rst_n   = 1'b1;
    wait_obs(4, 40, "t1");
    check_ids("t1_id", 0, '{0, 1, 2, 3});
    for (int i = 0; i < 4; i++) if (i < obs_last.size()) check("t1_last", 32'(obs_last[i]), 1);
    if (obs_cyc.size() > 0) check("t1_latency", obs_cyc[0], rel_cyc + 3);

    // Two streaming sources with 3-beat packets.
    repeat (3) @(negedge clk);
    clear_obs();
    push_pkt(0, 3, 32'b101);
    push_pkt(2, 3, 32'b010);
    push_pkt(0, 3, 32'b011);
    wait_obs(9, 80, "t2");
    check_ids("t2_id", 0, '{0, 0, 0, 2, 2, 2, 0, 0, 0});
    for (int i = 0; i < 9; i++) begin
      if (i < obs_last.size()) check("t2_last", 32'(obs_last[i]), 32'(i % 3 == 2));
      if (i > 0 && i < obs_cyc.size())
        check("t2_gap", obs_cyc[i] - obs_cyc[i-1], (i == 3 || i == 6) ? 2 : 1);
    end

    // Backpressure mid-packet from source 1.
    repeat (3) @(negedge clk);
    clear_obs();
    push_pkt(1, 3, 32'b101);
    wait_obs(1, 40, "t3a");
    @(posedge clk);
    #2;
    bus.m_ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t3_ready_held", 32'(bus.s_ready_o), 0);
      check("t3_valid_held", 32'(bus.m_valid_o), 1);
    end
    @(posedge clk);
    #2;
    bus.m_ready_i = 1'b1;
    wait_obs(3, 40, "t3b");
    check_ids("t3_id", 0, '{1, 1, 1});
    if (obs_last.size() > 2) check("t3_last", 32'(obs_last[2]), 1);

    // Enable mask: source 2 masked, source 0 masked mid-packet.
    repeat (3) @(negedge clk);
    clear_obs();
    bus.src_en_i = 4'b1011;
    push_pkt(3, 2, 32'b01);
    push_pkt(0, 2, 32'b10);
    push_pkt(0, 2, 32'b11);
    push_pkt(1, 2, 32'b01);
    push_pkt(2, 2, 32'b10);
    wait_obs(3, 60, "t4a");
    @(posedge clk);
    #2;
    bus.src_en_i = 4'b1010;
    wait_obs(6, 60, "t4b");
    repeat (10) @(negedge clk);
    check("t4_masked_count", obs_id.size(), 6);
    check_ids("t4_id_a", 0, '{3, 3, 0, 0, 1, 1});
    @(posedge clk);
    #2;
    bus.src_en_i = 4'b1011;
    wait_obs(8, 40, "t4c");
    check_ids("t4_id_b", 6, '{0, 0});
    @(posedge clk);
    #2;
    bus.src_en_i = 4'b1111;
    wait_obs(10, 40, "t4d");
    check_ids("t4_id_c", 8, '{2, 2});

    // Reset during beat 2 of a 4-beat packet.
    repeat (3) @(negedge clk);
    clear_obs();
    push_pkt(3, 4, 32'b1010);
    wait_obs(1, 40, "t6a");
    @(posedge clk);
    #2;
    check("t6_pre_valid", 32'(bus.m_valid_o), 1);
    check("t6_pre_busy", 32'(bus.busy_o), 1);
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(bus.m_valid_o), 0);
    check("t6_busy", 32'(bus.busy_o), 0);
    check("t6_last", 32'(bus.m_last_o), 0);
    check("t6_s_ready", 32'(bus.s_ready_o), 0);
    for (int s = 0; s < N; s++) begin
      src_q[s].delete();
      exp_q[s].delete();
    end
    push_pkt(1, 1, 32'b1);
    push_pkt(3, 1, 32'b0);
    repeat (3) @(posedge clk);
    #2;
    clear_obs();
    rst_n = 1'b1;
    wait_obs(2, 40, "t6b");
    repeat (10) @(negedge clk);
    check("t6_count", obs_id.size(), 2);
    check_ids("t6_id", 0, '{1, 3});

    for (int s = 0; s < N; s++) check("drain_exp", exp_q[s].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
